// File: rtl/torus_client_port.sv
// PE-side endpoint for one torus_switch_bp node: an injection FIFO feeding the switch's local
// port and an ejection FIFO draining its output. Define TORUS_CLIENT_STATS_EN to build tx/rx/stall counters.
module torus_client_port #(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 32,
  parameter int X     = 0,
  parameter int Y     = 0,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           src_v,
  input  logic [X_W-1:0] src_x,
  input  logic [Y_W-1:0] src_y,
  input  logic [D_W-1:0] src_data,
  output logic           src_rdy,
  output logic           i_v,
  output logic [X_W-1:0] i_x,
  output logic [Y_W-1:0] i_y,
  output logic [D_W-1:0] i_data,
  input  logic           i_ack,
  input  logic           o_v,
  input  logic [X_W-1:0] s_out_x,
  input  logic [Y_W-1:0] s_out_y,
  input  logic [D_W-1:0] s_out_data,
  output logic           ej_v,
  output logic [D_W-1:0] ej_data,
  input  logic           ej_rdy,
  output logic           ej_ovf,
  output logic           misroute,
  output logic [15:0]    tx_cnt,
  output logic [15:0]    rx_cnt,
  output logic [15:0]    stall_cnt,
  output logic           idle
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]  P_ONE = AW'(1);
  localparam logic [X_W-1:0] MY_X  = X_W'(X);
  localparam logic [Y_W-1:0] MY_Y  = Y_W'(Y);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [D_W-1:0] data;
  } pkt_t;

  // injection side
  pkt_t          inj_mem [DEPTH];
  pkt_t          inj_head;
  logic [AW-1:0] inj_wp, inj_rp;
  logic [AW:0]   inj_cnt;
  logic          inj_push, inj_pop;

  assign src_rdy  = inj_cnt != FULL;
  assign inj_push = src_v && src_rdy;
  assign i_v      = inj_cnt != '0;
  assign inj_pop  = i_v && i_ack;
  assign inj_head = inj_mem[inj_rp];
  assign i_x      = inj_head.x;
  assign i_y      = inj_head.y;
  assign i_data   = inj_head.data;

  always_ff @(posedge clk)
    if (inj_push) inj_mem[inj_wp] <= {src_x, src_y, src_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_wp  <= '0;
      inj_rp  <= '0;
      inj_cnt <= '0;
    end else begin
      if (inj_push) inj_wp <= inj_wp + P_ONE;
      if (inj_pop)  inj_rp <= inj_rp + P_ONE;
      case ({inj_push, inj_pop})
        2'b10:   inj_cnt <= inj_cnt + C_ONE;
        2'b01:   inj_cnt <= inj_cnt - C_ONE;
        default: ;
      endcase
    end
  end

  // ejection side: a pop in the same cycle frees the slot a full FIFO needs
  logic [D_W-1:0] ej_mem [DEPTH];
  logic [AW-1:0]  ej_wp, ej_rp;
  logic [AW:0]    ej_cnt;
  logic           ej_push, ej_pop;

  assign ej_v    = ej_cnt != '0;
  assign ej_pop  = ej_v && ej_rdy;
  assign ej_push = o_v && ((ej_cnt != FULL) || ej_pop);
  assign ej_data = ej_mem[ej_rp];

  always_ff @(posedge clk)
    if (ej_push) ej_mem[ej_wp] <= s_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ej_wp    <= '0;
      ej_rp    <= '0;
      ej_cnt   <= '0;
      ej_ovf   <= 1'b0;
      misroute <= 1'b0;
    end else begin
      if (ej_push) ej_wp <= ej_wp + P_ONE;
      if (ej_pop)  ej_rp <= ej_rp + P_ONE;
      case ({ej_push, ej_pop})
        2'b10:   ej_cnt <= ej_cnt + C_ONE;
        2'b01:   ej_cnt <= ej_cnt - C_ONE;
        default: ;
      endcase
      if (o_v && !ej_push) ej_ovf <= 1'b1;
      if (o_v && (s_out_x != MY_X || s_out_y != MY_Y)) misroute <= 1'b1;
    end
  end

`ifdef TORUS_CLIENT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (inj_pop)         tx_cnt    <= tx_cnt + 16'd1;
      if (ej_push)         rx_cnt    <= rx_cnt + 16'd1;
      if (i_v && !i_ack)   stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign tx_cnt    = '0;
  assign rx_cnt    = '0;
  assign stall_cnt = '0;
`endif

  assign idle = !i_v && !ej_v && !src_v;
endmodule

// File: tb/tb_torus_client_port.sv
// Bench for torus_client_port: directed table, hand-written corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_torus_client_port;
  localparam int X_W = 2, Y_W = 2, D_W = 32, DEPTH = 4;
`ifdef TORUS_CLIENT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic src_v, src_rdy, i_v, i_ack, o_v, ej_v, ej_rdy, ej_ovf, misroute, idle;
  logic [X_W-1:0] src_x, i_x, s_out_x;
  logic [Y_W-1:0] src_y, i_y, s_out_y;
  logic [D_W-1:0] src_data, i_data, s_out_data, ej_data;
  logic [15:0] tx_cnt, rx_cnt, stall_cnt;

  always #5 clk = ~clk;

  torus_client_port #(.X_W(X_W), .Y_W(Y_W), .D_W(D_W), .X(0), .Y(0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .src_v(src_v), .src_x(src_x), .src_y(src_y), .src_data(src_data), .src_rdy(src_rdy),
    .i_v(i_v), .i_x(i_x), .i_y(i_y), .i_data(i_data), .i_ack(i_ack),
    .o_v(o_v), .s_out_x(s_out_x), .s_out_y(s_out_y), .s_out_data(s_out_data),
    .ej_v(ej_v), .ej_data(ej_data), .ej_rdy(ej_rdy),
    .ej_ovf(ej_ovf), .misroute(misroute),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .stall_cnt(stall_cnt), .idle(idle)
  );

  int checks = 0, failures = 0;

  // reference model: plain queues plus counters
  logic [35:0] m_inj[$];
  logic [31:0] m_ej[$];
  logic [15:0] m_tx = 0, m_rx = 0, m_stall = 0;
  logic        m_ovf = 0, m_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] st(input logic [15:0] v);
    return (STATS != 0) ? v : 16'd0;
  endfunction

  task automatic check_model();
    chk("src_rdy", src_rdy, m_inj.size() < DEPTH);
    chk("i_v", i_v, m_inj.size() != 0);
    if (m_inj.size() != 0) chk("i_head", {i_x, i_y, i_data}, m_inj[0]);
    chk("ej_v", ej_v, m_ej.size() != 0);
    if (m_ej.size() != 0) chk("ej_data", ej_data, m_ej[0]);
    chk("ej_ovf", ej_ovf, m_ovf);
    chk("misroute", misroute, m_mis);
    chk("tx_cnt", tx_cnt, st(m_tx));
    chk("rx_cnt", rx_cnt, st(m_rx));
    chk("stall_cnt", stall_cnt, st(m_stall));
    chk("idle", idle, m_inj.size() == 0 && m_ej.size() == 0 && !src_v);
  endtask

  // applies the current inputs to the model, then crosses the clock edge
  task automatic advance();
    bit ipop, ipush, epop, epush;
    if (rst) begin
      m_inj.delete(); m_ej.delete();
      m_tx = 0; m_rx = 0; m_stall = 0; m_ovf = 0; m_mis = 0;
    end else begin
      ipop  = m_inj.size() > 0 && i_ack;
      ipush = src_v && m_inj.size() < DEPTH;
      epop  = m_ej.size() > 0 && ej_rdy;
      epush = o_v && (m_ej.size() < DEPTH || epop);
      if (m_inj.size() > 0 && !i_ack) m_stall++;
      if (o_v && !epush) m_ovf = 1;
      if (o_v && (s_out_x != 0 || s_out_y != 0)) m_mis = 1;
      if (ipop) begin void'(m_inj.pop_front()); m_tx++; end
      if (ipush) m_inj.push_back({src_x, src_y, src_data});
      if (epop) void'(m_ej.pop_front());
      if (epush) begin m_ej.push_back(s_out_data); m_rx++; end
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    src_v = 0; src_x = 0; src_y = 0; src_data = 0; i_ack = 0;
    o_v = 0; s_out_x = 0; s_out_y = 0; s_out_data = 0; ej_rdy = 0;
  endtask

  task automatic reset_dut();
    quiet(); rst = 1;
    #3; advance();
    rst = 0;
  endtask

  typedef struct {
    logic sv; logic [1:0] sx; logic [31:0] sd; logic ack; logic ov; logic [31:0] od; logic er;
    logic e_rdy; logic e_iv; logic [1:0] e_ix; logic [31:0] e_id; logic e_ev; logic [31:0] e_ed;
    logic [15:0] e_tx; logic [15:0] e_rx; logic e_idle;
  } vec_t;
  vec_t tbl[7];

  int d;
  logic [31:0] exp_ej[4];

  initial begin
    tbl[0] = '{1, 1, 32'hA5, 1, 0, 0,     1,  1, 0, 0, 0,     0, 0,     0, 0, 0};
    tbl[1] = '{0, 0, 0,      1, 0, 0,     1,  1, 1, 1, 32'hA5, 0, 0,    0, 0, 0};
    tbl[2] = '{0, 0, 0,      1, 1, 32'h10, 1, 1, 0, 0, 0,     0, 0,     1, 0, 1};
    tbl[3] = '{0, 0, 0,      1, 1, 32'h11, 1, 1, 0, 0, 0,     1, 32'h10, 1, 1, 0};
    tbl[4] = '{0, 0, 0,      1, 1, 32'h12, 1, 1, 0, 0, 0,     1, 32'h11, 1, 2, 0};
    tbl[5] = '{0, 0, 0,      1, 0, 0,     1,  1, 0, 0, 0,     1, 32'h12, 1, 3, 0};
    tbl[6] = '{0, 0, 0,      1, 0, 0,     1,  1, 0, 0, 0,     0, 0,     1, 3, 1};

    // reset state
    reset_dut();
    #3;
    chk("rst i_v", i_v, 0);
    chk("rst ej_v", ej_v, 0);
    chk("rst src_rdy", src_rdy, 1);
    chk("rst idle", idle, 1);
    chk("rst tx_cnt", tx_cnt, 0);
    check_model();
    advance();

    // one packet out, three in
    for (int k = 0; k < 7; k++) begin
      src_v = tbl[k].sv; src_x = tbl[k].sx; src_y = 0; src_data = tbl[k].sd; i_ack = tbl[k].ack;
      o_v = tbl[k].ov; s_out_x = 0; s_out_y = 0; s_out_data = tbl[k].od; ej_rdy = tbl[k].er;
      #3;
      chk($sformatf("vec%0d src_rdy", k), src_rdy, tbl[k].e_rdy);
      chk($sformatf("vec%0d i_v", k), i_v, tbl[k].e_iv);
      if (tbl[k].e_iv) chk($sformatf("vec%0d i_x/i_data", k), {i_x, i_data}, {tbl[k].e_ix, tbl[k].e_id});
      chk($sformatf("vec%0d ej_v", k), ej_v, tbl[k].e_ev);
      if (tbl[k].e_ev) chk($sformatf("vec%0d ej_data", k), ej_data, tbl[k].e_ed);
      chk($sformatf("vec%0d tx_cnt", k), tx_cnt, st(tbl[k].e_tx));
      chk($sformatf("vec%0d rx_cnt", k), rx_cnt, st(tbl[k].e_rx));
      chk($sformatf("vec%0d idle", k), idle, tbl[k].e_idle);
      check_model();
      advance();
    end

    // backpressure: head holds for 10 stalled cycles, then drains in order
    reset_dut();
    d = 1; src_v = 1;
    for (int k = 0; k < 11; k++) begin
      src_data = d;
      #3; check_model();
      if (m_inj.size() < DEPTH) begin advance(); d++; end
      else advance();
    end
    src_data = d;
    #3;
    chk("bp src_rdy", src_rdy, 0);
    chk("bp head", i_data, 1);
    chk("bp stall_cnt", stall_cnt, st(10));
    src_v = 0; i_ack = 1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) #3;
      chk($sformatf("bp drain%0d", k), {i_v, i_data}, {1'b1, 32'(k + 1)});
      check_model();
      advance();
    end
    #3;
    chk("bp empty", i_v, 0);
    chk("bp tx_cnt", tx_cnt, st(4));
    check_model(); advance();

    // ejection overflow, then push+pop while full
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      o_v = 1; s_out_data = 32'h20 + k;
      #3; check_model(); advance();
    end
    o_v = 1; s_out_data = 32'h25; ej_rdy = 1;
    #3;
    chk("ovf flag", ej_ovf, 1);
    chk("ovf rx_cnt", rx_cnt, st(4));
    chk("ovf head", ej_data, 32'h20);
    check_model(); advance();
    o_v = 0;
    exp_ej = '{32'h21, 32'h22, 32'h23, 32'h25};
    for (int k = 0; k < 4; k++) begin
      #3;
      chk($sformatf("ovf order%0d", k), {ej_v, ej_data}, {1'b1, exp_ej[k]});
      check_model(); advance();
    end
    #3;
    chk("ovf sticky", ej_ovf, 1);
    chk("ovf rx_cnt after", rx_cnt, st(5));
    check_model(); advance();

    // misroute is sticky and the packet still arrives
    reset_dut();
    o_v = 1; s_out_x = 1; s_out_data = 32'h33;
    #3;
    chk("mis before", misroute, 0);
    check_model(); advance();
    quiet();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("mis sticky%0d", k), misroute, 1);
      chk($sformatf("mis data%0d", k), {ej_v, ej_data}, {1'b1, 32'h33});
      check_model(); advance();
    end

    // reset with traffic in both FIFOs
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      src_v = 1; src_data = 32'h40 + k;
      o_v = 1; s_out_data = 32'h50 + k; s_out_y = (k == 0) ? 2'd1 : 2'd0;
      #3; check_model(); advance();
    end
    quiet();
    #3; check_model(); advance();
    rst = 1;
    #3; check_model(); advance();
    rst = 0;
    #3;
    chk("mid-rst i_v", i_v, 0);
    chk("mid-rst ej_v", ej_v, 0);
    chk("mid-rst flags", {ej_ovf, misroute}, 0);
    chk("mid-rst counters", {tx_cnt, rx_cnt, stall_cnt}, 0);
    chk("mid-rst idle", idle, 1);
    chk("mid-rst src_rdy", src_rdy, 1);
    check_model(); advance();

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      src_v = $urandom_range(0, 1);
      src_x = 2'($urandom); src_y = 2'($urandom); src_data = $urandom;
      i_ack = $urandom_range(0, 1);
      o_v = $urandom_range(0, 1);
      s_out_x = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      s_out_y = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      s_out_data = $urandom;
      ej_rdy = ($urandom_range(0, 3) != 0);
      #3; check_model(); advance();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/torus_client_port.md
Name: torus_client_port

Overview:
- Client-side endpoint that sits between a processing element and one torus_switch_bp node.
- Feeds the switch's local injection port (i_v/i_x/i_y/i_data, retired by i_ack).
- Consumes the switch's ejection stream (o_v qualifying s_out_x/s_out_y/s_out_data).
- Buffers both directions in small FIFOs, so the PE and switch are decoupled and the switch never has to hold a packet for the PE.

Parameters:
- X_W, 2, X address width
- Y_W, 2, Y address width
- D_W, 32, payload width
- X, 0, X address of the attached switch
- Y, 0, Y address of the attached switch
- DEPTH, 4, entries per FIFO; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset
- src_v  in  1  PE injection request valid
- src_x  in  X_W  destination X
- src_y  in  Y_W  destination Y
- src_data  in  D_W  payload
- src_rdy  out  1  injection FIFO can accept
- i_v  out  1  to switch: injection valid
- i_x  out  X_W  to switch: destination X
- i_y  out  Y_W  to switch: destination Y
- i_data  out  D_W  to switch: payload
- i_ack  in  1  from switch: head accepted this cycle
- o_v  in  1  from switch: ejected packet valid
- s_out_x  in  X_W  ejected packet X
- s_out_y  in  Y_W  ejected packet Y
- s_out_data  in  D_W  ejected payload
- ej_v  out  1  ejection FIFO head valid to PE
- ej_data  out  D_W  ejection head payload
- ej_rdy  in  1  PE consumes ejection head
- ej_ovf  out  1  sticky: ejected packet dropped (FIFO full)
- misroute  out  1  sticky: ejected packet address != (X,Y)
- tx_cnt  out  16  packets injected (stats)
- rx_cnt  out  16  packets ejected into FIFO (stats)
- stall_cnt  out  16  cycles with i_v=1 and i_ack=0 (stats)
- idle  out  1  both FIFOs empty and src_v=0

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - Both FIFO pointers and occupancy counts are cleared.
  - All of these are 0 the cycle after rst: ej_ovf, misroute, tx_cnt, rx_cnt, stall_cnt.
  - Hence after reset: i_v=0, ej_v=0, src_rdy=1, idle=!src_v.
  - rst mid-operation discards all buffered packets; no partial state survives.
- Injection FIFO:
  - src_rdy = !inj_full. This is combinational from occupancy only; there is no same-cycle pop bypass.
  - Push on src_v && src_rdy.
  - i_v = !inj_empty. i_x, i_y and i_data are the head entry, driven combinationally from FIFO storage.
  - Pop on i_v && i_ack. An i_ack with i_v=0 is ignored.
  - Head stays stable while i_v=1 and i_ack=0.
  - No empty bypass: a packet accepted in cycle t appears on i_v in cycle t+1 at the earliest.
  - Simultaneous push and pop keeps occupancy unchanged. Pointers wrap modulo DEPTH; occupancy counts 0..DEPTH.
- Ejection FIFO:
  - Capture {s_out_data} when o_v=1; the switch output is already registered.
  - Push is accepted if !ej_full || (ej_v && ej_rdy), i.e. a same-cycle pop frees a slot.
  - If o_v=1 and the push is not accepted, the packet is dropped and ej_ovf sets; it holds until rst.
  - ej_v = !ej_empty. Pop on ej_v && ej_rdy.
  - Latency from o_v to ej_v is 1 cycle.
  - misroute sets on o_v && (s_out_x != X || s_out_y != Y), regardless of drop. The packet is still captured if space allows.
- Counters:
  - tx_cnt increments on pop.
  - rx_cnt increments on accepted ejection push.
  - stall_cnt increments on i_v && !i_ack.
  - All wrap at 2^16.
- idle is combinational.

Optional Feature:
- Macro: TORUS_CLIENT_STATS_EN.
- Defined: tx_cnt, rx_cnt and stall_cnt are implemented as described.
- Undefined: the counter registers are not built; the three ports remain and are tied to 0.
- ej_ovf and misroute are present in both cases.

Test Plan:
- Reset then one packet: src (x=1, y=0, data=0xA5) in cycle t with i_ack tied to i_v -> i_v=1 with the same fields in t+1; tx_cnt=1 in t+2; src_rdy=1 throughout.
- Backpressure: i_ack=0 for 10 cycles while src_v=1 with data 1..8, DEPTH=4 -> src_rdy=0 after 4 accepts; head holds data=1; stall_cnt=10; releasing i_ack drains 1,2,3,4 in order.
- Ejection ordering: o_v pulses with data 0x10, 0x11, 0x12 on consecutive cycles, ej_rdy=1 -> ej_v=1 one cycle after each pulse, data in order; rx_cnt=3.
- Ejection overflow: ej_rdy=0 with 5 o_v pulses (DEPTH=4) -> the 5th is dropped; ej_ovf=1; rx_cnt=4. Then ej_rdy=1 together with o_v while full -> pop and push in the same cycle, no drop.
- Misroute: o_v with s_out_x=X+1 -> misroute=1 next cycle and sticky; the packet is still delivered on ej_data.
- Reset mid-traffic: rst with both FIFOs holding 3 entries -> next cycle i_v=0, ej_v=0, all counters and flags 0, idle=1 with src_v=0.
